// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Front end of the multicycle MIPS core. Owns the PC, fetches one
//   instruction at a time over iREN/ihit and holds it stable for the
//   decoder. Runs the data-memory phase (dREN/dWEN until dhit) for loads
//   and stores. Selects the next PC from the decoder's PCsrc and holds a
//   sticky halt.
// Ports
//   CLK, nRST            clock (rising edge), async active-low reset
//   ihit, imemload       instruction memory handshake / data
//   imemaddr, iREN       fetch address (= PC), fetch request
//   instr                registered instruction word for the decoder
//   cu_dREN/dWEN/halt    decoder classification of the current instr
//   PCsrc, br_taken      next-PC select and branch condition
//   imm_addr, j_addr     branch offset and jump target fields
//   rs_data              JR target register value
//   dhit, dREN, dWEN     data memory handshake / requests
//   pc_plus4             PC+4 of the current instr (JAL link value)
//   wb_en                retire strobe for the current instr
//   halt                 sticky halt flag
module fetch_sequencer #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic [31:0] imemaddr,
    output logic        iREN,
    output logic [31:0] instr,
    input  logic        cu_dREN,
    input  logic        cu_dWEN,
    input  logic        cu_halt,
    input  logic [1:0]  PCsrc,
    input  logic        br_taken,
    input  logic [15:0] imm_addr,
    input  logic [25:0] j_addr,
    input  logic [31:0] rs_data,
    input  logic        dhit,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] pc_plus4,
    output logic        wb_en,
    output logic        halt
);

    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALTED} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_halt;
    logic        r_dren;
    logic        r_dwen;

    logic [31:0] w_pc4;
    logic [31:0] w_br_off;
    logic [31:0] w_next_pc;
    logic        w_mem_req;
    logic        w_retire;

    assign w_pc4     = r_pc + 32'd4;
    assign w_br_off  = {{14{imm_addr[15]}}, imm_addr, 2'b00};
    assign w_mem_req = cu_dREN | cu_dWEN;

    always_comb begin
        w_next_pc = w_pc4;
        case (PCsrc)
            2'b00: w_next_pc = w_pc4;
            2'b01: w_next_pc = br_taken ? (w_pc4 + w_br_off) : w_pc4;
            2'b10: w_next_pc = {w_pc4[31:28], j_addr, 2'b00};
            // JR target: misaligned low bits are dropped, not trapped
            default: w_next_pc = rs_data & 32'hFFFF_FFFC;
        endcase
    end

    // Retire is combinational so the register write lands in the same
    // cycle the PC advances; pc_plus4 still reflects the retiring instr.
    assign w_retire = ((r_state == EXEC) && !cu_halt && !w_mem_req) ||
                      ((r_state == MEM) && dhit);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= FETCH;
            r_pc    <= PC_INIT;
            r_instr <= 32'h0;
            r_halt  <= 1'b0;
            r_dren  <= 1'b0;
            r_dwen  <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (ihit) begin
                        r_instr <= imemload;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    // halt wins over a memory op decoded in the same instr
                    if (cu_halt) begin
                        r_halt  <= 1'b1;
                        r_state <= HALTED;
                    end else if (w_mem_req) begin
                        // a conflicting load+store resolves to the store
                        r_dwen  <= cu_dWEN;
                        r_dren  <= cu_dREN & ~cu_dWEN;
                        r_state <= MEM;
                    end else begin
                        r_pc    <= w_next_pc;
                        r_state <= FETCH;
                    end
                end
                MEM: begin
                    if (dhit) begin
                        r_dren  <= 1'b0;
                        r_dwen  <= 1'b0;
                        r_pc    <= w_next_pc;
                        r_state <= FETCH;
                    end
                end
                default: r_state <= HALTED;
            endcase
        end
    end

    assign imemaddr = r_pc;
    assign iREN     = (r_state == FETCH);
    assign instr    = r_instr;
    assign dREN     = r_dren;
    assign dWEN     = r_dwen;
    assign pc_plus4 = w_pc4;
    assign wb_en    = w_retire;
    assign halt     = r_halt;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit = 1'b0;
    logic [31:0] imemload = '0;
    logic [31:0] imemaddr;
    logic        iREN;
    logic [31:0] instr;
    logic        cu_dREN = 1'b0, cu_dWEN = 1'b0, cu_halt = 1'b0;
    logic [1:0]  PCsrc = 2'b00;
    logic        br_taken = 1'b0;
    logic [15:0] imm_addr = '0;
    logic [25:0] j_addr = '0;
    logic [31:0] rs_data = '0;
    logic        dhit = 1'b0;
    logic        dREN, dWEN;
    logic [31:0] pc_plus4;
    logic        wb_en, halt;

    fetch_sequencer dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
        .imemaddr(imemaddr), .iREN(iREN), .instr(instr),
        .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN), .cu_halt(cu_halt),
        .PCsrc(PCsrc), .br_taken(br_taken), .imm_addr(imm_addr),
        .j_addr(j_addr), .rs_data(rs_data), .dhit(dhit), .dREN(dREN),
        .dWEN(dWEN), .pc_plus4(pc_plus4), .wb_en(wb_en), .halt(halt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_pc;
    int          n_cmp = 0;
    int          n_err = 0;

    // observations from the last do_instr
    logic [31:0] o_pc, o_instr, o_pc4;
    logic        o_wb, o_stall_ok, o_fetch_ok, o_req_after;

    function automatic logic [31:0] m_next(input logic [31:0] pc, input logic [1:0] src,
                                           input logic br, input logic [15:0] imm,
                                           input logic [25:0] j, input logic [31:0] rs);
        logic [31:0] seq;
        int          off;
        logic [31:0] r;
        seq = pc + 32'd4;
        off = int'($signed(imm)) * 4;
        case (src)
            2'd0:    r = seq;
            2'd1:    r = br ? seq + 32'(off) : seq;
            2'd2:    r = {seq[31:28], j, 2'b00};
            default: r = {rs[31:2], 2'b00};
        endcase
        return r;
    endfunction

    // Drive one instruction through fetch/exec(/mem); push expected retire.
    task automatic do_instr(input logic [31:0] w, input logic [1:0] src, input logic br,
                            input logic [15:0] imm, input logic [25:0] j, input logic [31:0] rs,
                            input logic ld, input logic st, input int dwait);
        exp_t e;
        @(negedge CLK);
        imemload = w; ihit = 1'b1; cu_dREN = ld; cu_dWEN = st; cu_halt = 1'b0;
        PCsrc = src; br_taken = br; imm_addr = imm; j_addr = j; rs_data = rs;
        e.instr = w;
        e.pc    = m_next(m_pc, src, br, imm, j, rs);
        sb.push_back(e);
        #1 o_fetch_ok = (iREN === 1'b1) && (imemaddr === m_pc);
        @(negedge CLK);
        ihit = 1'b0; imemload = $urandom;
        #1 o_instr = instr;
        o_stall_ok = 1'b1;
        if (ld | st) begin
            if (wb_en !== 1'b0) o_stall_ok = 1'b0;
            for (int k = 0; k < dwait; k++) begin
                @(negedge CLK);
                #1;
                if (dREN !== (ld & ~st) || dWEN !== st || imemaddr !== m_pc || wb_en !== 1'b0)
                    o_stall_ok = 1'b0;
            end
            @(negedge CLK);
            dhit = 1'b1; ihit = 1'b1;
            #1 o_wb = wb_en;
            if (dREN !== (ld & ~st) || dWEN !== st) o_stall_ok = 1'b0;
            @(negedge CLK);
            dhit = 1'b0; ihit = 1'b0;
        end else begin
            o_wb = wb_en;
            @(negedge CLK);
        end
        #1;
        o_pc        = imemaddr;
        o_pc4       = pc_plus4;
        o_req_after = dREN | dWEN;
        m_pc        = e.pc;
    endtask

    task automatic test_reset;
        nRST = 1'b0;
        #2;
        if (imemaddr !== 32'h0) begin $display("FAIL reset_pc got %h exp %h", imemaddr, 32'h0); n_err++; end
        n_cmp++;
        if (iREN !== 1'b1) begin $display("FAIL reset_iREN got %b exp 1", iREN); n_err++; end
        n_cmp++;
        if (instr !== 32'h0) begin $display("FAIL reset_instr got %h exp 0", instr); n_err++; end
        n_cmp++;
        if ({dREN, dWEN, wb_en, halt} !== 4'b0) begin
            $display("FAIL reset_ctl got %b exp 0000", {dREN, dWEN, wb_en, halt}); n_err++;
        end
        n_cmp++;
        @(negedge CLK);
        nRST = 1'b1;
        m_pc = 32'h0;
        sb.delete();
    endtask

    task automatic test_alu;
        exp_t e;
        do_instr(32'h2001_0005, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 0);
        e = sb.pop_front();
        if (!o_fetch_ok) begin $display("FAIL alu_fetch iREN/addr wrong exp addr %h", e.pc - 32'd4); n_err++; end
        n_cmp++;
        if (o_instr !== 32'h2001_0005) begin $display("FAIL alu_instr got %h exp %h", o_instr, 32'h2001_0005); n_err++; end
        n_cmp++;
        if (o_wb !== 1'b1) begin $display("FAIL alu_wb got %b exp 1", o_wb); n_err++; end
        n_cmp++;
        if (o_pc !== 32'h4 || o_pc !== e.pc) begin $display("FAIL alu_pc got %h exp %h", o_pc, 32'h4); n_err++; end
        n_cmp++;
    endtask

    task automatic test_branch;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            do_instr(32'h0000_0020 + i, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 0);
            e = sb.pop_front();
        end
        if (o_pc !== 32'h10) begin $display("FAIL seq_pc got %h exp %h", o_pc, 32'h10); n_err++; end
        n_cmp++;
        do_instr(32'h1000_FFFF, 2'b01, 1'b1, 16'hFFFF, 26'h0, 32'h0, 1'b0, 1'b0, 0);
        e = sb.pop_front();
        if (o_pc !== 32'h10 || e.pc !== 32'h10) begin $display("FAIL br_taken got %h exp %h", o_pc, 32'h10); n_err++; end
        n_cmp++;
        do_instr(32'h1000_FFFF, 2'b01, 1'b0, 16'hFFFF, 26'h0, 32'h0, 1'b0, 1'b0, 0);
        e = sb.pop_front();
        if (o_pc !== 32'h14) begin $display("FAIL br_not_taken got %h exp %h", o_pc, 32'h14); n_err++; end
        n_cmp++;
    endtask

    task automatic test_jump;
        exp_t e;
        do_instr(32'h03E0_0008, 2'b11, 1'b0, 16'h0, 26'h0, 32'h8000_0010, 1'b0, 1'b0, 0);
        e = sb.pop_front();
        if (o_pc !== 32'h8000_0010) begin $display("FAIL jr_pc got %h exp %h", o_pc, 32'h8000_0010); n_err++; end
        n_cmp++;
        do_instr(32'h0800_0040, 2'b10, 1'b0, 16'h0, 26'h0000040, 32'h0, 1'b0, 1'b0, 0);
        e = sb.pop_front();
        if (o_pc !== 32'h8000_0100) begin $display("FAIL j_pc got %h exp %h", o_pc, 32'h8000_0100); n_err++; end
        n_cmp++;
        do_instr(32'h03E0_0008, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_0203, 1'b0, 1'b0, 0);
        e = sb.pop_front();
        if (o_pc !== 32'h200) begin $display("FAIL jr_align got %h exp %h", o_pc, 32'h200); n_err++; end
        n_cmp++;
        do_instr(32'h03E0_0008, 2'b11, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        e = sb.pop_front();
        if (o_pc4 !== 32'h0) begin $display("FAIL pc4_wrap got %h exp %h", o_pc4, 32'h0); n_err++; end
        n_cmp++;
        do_instr(32'h0000_0000, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 0);
        e = sb.pop_front();
        if (o_pc !== 32'h0) begin $display("FAIL pc_wrap got %h exp %h", o_pc, 32'h0); n_err++; end
        n_cmp++;
    endtask

    task automatic test_mem;
        exp_t e;
        do_instr(32'h8C22_0000, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b0, 3);
        e = sb.pop_front();
        if (!o_stall_ok) begin $display("FAIL load_stall req/pc/wb wrong during wait exp dREN=1 pc=%h", e.pc - 32'd4); n_err++; end
        n_cmp++;
        if (o_wb !== 1'b1) begin $display("FAIL load_wb got %b exp 1", o_wb); n_err++; end
        n_cmp++;
        if (o_pc !== 32'h4) begin $display("FAIL load_pc got %h exp %h", o_pc, 32'h4); n_err++; end
        n_cmp++;
        if (o_req_after !== 1'b0) begin $display("FAIL load_drop got %b exp 0", o_req_after); n_err++; end
        n_cmp++;
        // decoder asserting both: store wins
        do_instr(32'hAC22_0000, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b1, 1);
        e = sb.pop_front();
        if (!o_stall_ok) begin $display("FAIL both_req exp dREN=0 dWEN=1 during wait"); n_err++; end
        n_cmp++;
        if (o_pc !== e.pc || o_pc !== 32'h8) begin $display("FAIL store_pc got %h exp %h", o_pc, 32'h8); n_err++; end
        n_cmp++;
    endtask

    task automatic test_halt;
        logic [31:0] hpc;
        hpc = m_pc;
        @(negedge CLK);
        imemload = 32'hFFFF_FFFF; ihit = 1'b1; cu_halt = 1'b1; cu_dWEN = 1'b1; cu_dREN = 1'b0;
        @(negedge CLK);
        ihit = 1'b0;
        #1;
        if (wb_en !== 1'b0 || dWEN !== 1'b0) begin $display("FAIL halt_exec wb=%b dWEN=%b exp 0 0", wb_en, dWEN); n_err++; end
        n_cmp++;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            ihit = 1'b1; dhit = 1'b1; imemload = $urandom;
            #1;
            if ({halt, iREN, dWEN, dREN, wb_en} !== 5'b10000 || imemaddr !== hpc) begin
                $display("FAIL halt_hold cyc %0d got h/i/w/r/wb=%b pc=%h exp 10000 pc=%h",
                         i, {halt, iREN, dWEN, dREN, wb_en}, imemaddr, hpc);
                n_err++;
            end
            n_cmp++;
        end
        ihit = 1'b0; dhit = 1'b0; cu_halt = 1'b0; cu_dWEN = 1'b0;
    endtask

    task automatic test_reset_mem;
        exp_t e;
        @(negedge CLK);
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1; m_pc = 32'h0;
        @(negedge CLK);
        imemload = 32'hAC00_0000; ihit = 1'b1; cu_dWEN = 1'b1; PCsrc = 2'b00;
        @(negedge CLK);
        ihit = 1'b0;
        @(negedge CLK);
        #1;
        if (dWEN !== 1'b1) begin $display("FAIL rst_mem_pre got dWEN=%b exp 1", dWEN); n_err++; end
        n_cmp++;
        nRST = 1'b0;
        #1;
        if (dWEN !== 1'b0 || imemaddr !== 32'h0 || wb_en !== 1'b0) begin
            $display("FAIL rst_mem_abort got dWEN=%b pc=%h wb=%b exp 0 0 0", dWEN, imemaddr, wb_en); n_err++;
        end
        n_cmp++;
        @(negedge CLK);
        nRST = 1'b1; cu_dWEN = 1'b0;
        do_instr(32'h2001_0005, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 0);
        e = sb.pop_front();
        if (!o_fetch_ok || o_pc !== 32'h4) begin $display("FAIL rst_mem_resume got pc=%h exp %h", o_pc, 32'h4); n_err++; end
        n_cmp++;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic [1:0] src;
        logic       ld, st;
        for (int i = 0; i < 8; i++) begin
            src = 2'($urandom_range(0, 3));
            ld  = 1'($urandom_range(0, 1));
            st  = (i % 3 == 0);
            do_instr($urandom, src, 1'($urandom), 16'($urandom), 26'($urandom), $urandom,
                     ld, st, int'($urandom_range(0, 2)));
            e = sb.pop_front();
            if (o_pc !== e.pc || o_instr !== e.instr || o_wb !== 1'b1 || !o_stall_ok) begin
                $display("FAIL b2b %0d got pc=%h instr=%h wb=%b ok=%b exp pc=%h instr=%h wb=1 ok=1",
                         i, o_pc, o_instr, o_wb, o_stall_ok, e.pc, e.instr);
                n_err++;
            end
            n_cmp++;
        end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_branch;
        test_jump;
        test_mem;
        test_halt;
        test_reset_mem;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
